// File: rtl/i2c_target_regfile.sv
// ---------------------------------------------------------------------------
// i2c_target_regfile
//
// I2C target that serves a small byte-wide register file behind a 16-bit
// register index. It lets camera / MIPI-bridge configuration masters run a
// full write/read configuration sequence without the real device attached.
// SCL and SDA are oversampled on the 50 MHz system clock. The block never
// stretches SCL.
//
// Parameters
//   DEV_ADDR : 7-bit target address that is acknowledged
//   AW       : register-file index width (depth 2**AW, aliases modulo 2**AW)
//   FILT     : consecutive equal samples needed to accept a new SCL/SDA level
//
// Ports
//   CLK_50   in     system clock, all logic on its rising edge
//   RESET_N  in     asynchronous active-low reset
//   I2C_SCL  in     bus clock from the master
//   I2C_SDA  inout  open-drain data; only ever driven low, otherwise Z
//   WR_STB   out    one-cycle pulse per byte written into the register file
//   WR_ADDR  out    register address of the last written byte
//   WR_DATA  out    value of the last written byte
//   BUSY     out    high from an acknowledged device address until STOP
// ---------------------------------------------------------------------------
module i2c_target_regfile #(
  parameter logic [6:0] DEV_ADDR = 7'h0E,
  parameter int         AW       = 8,
  parameter int         FILT     = 3
) (
  input  logic        CLK_50,
  input  logic        RESET_N,
  input  logic        I2C_SCL,
  inout  wire         I2C_SDA,
  output logic        WR_STB,
  output logic [15:0] WR_ADDR,
  output logic [7:0]  WR_DATA,
  output logic        BUSY
);

  localparam int CW = (FILT > 1) ? $clog2(FILT) : 1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV,
    ST_ACK,
    ST_HI,
    ST_LO,
    ST_WD,
    ST_RD,
    ST_MACK,
    ST_IGNORE
  } state_t;

  // -------------------------------------------------------------------------
  // Input conditioning: bit 0 = SCL, bit 1 = SDA
  // -------------------------------------------------------------------------
  logic [1:0] raw_in;
  logic [1:0] filt_vec;

  assign raw_in = {I2C_SDA, I2C_SCL};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_in
      logic          sync1_reg;
      logic          sync2_reg;
      logic          filt_reg;
      logic [CW-1:0] cnt_reg;

      // A new level is accepted only after FILT consecutive samples differ
      // from the current filtered level; anything shorter is a glitch.
      always_ff @(posedge CLK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
          sync1_reg <= 1'b1;
          sync2_reg <= 1'b1;
          filt_reg  <= 1'b1;
          cnt_reg   <= '0;
        end else begin
          sync1_reg <= raw_in[gi];
          sync2_reg <= sync1_reg;
          if (sync2_reg == filt_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == CW'(FILT - 1)) begin
            filt_reg <= sync2_reg;
            cnt_reg  <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

      assign filt_vec[gi] = filt_reg;
    end
  endgenerate

  logic scl_f;
  logic sda_f;
  logic scl_prev_reg;
  logic sda_prev_reg;
  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  assign scl_f    = filt_vec[0];
  assign sda_f    = filt_vec[1];
  assign scl_rise = scl_f & ~scl_prev_reg;
  assign scl_fall = ~scl_f & scl_prev_reg;
  // SCL must be high on both samples so a simultaneous SCL/SDA change is
  // never mistaken for START or STOP.
  assign start_det = scl_f & scl_prev_reg & sda_prev_reg & ~sda_f;
  assign stop_det  = scl_f & scl_prev_reg & ~sda_prev_reg & sda_f;

  // -------------------------------------------------------------------------
  // Protocol state
  // -------------------------------------------------------------------------
  state_t      state_reg;
  state_t      ack_next_reg;   // state to resume once the ACK slot ends
  logic        phase_reg;      // ACK: slot driven; MACK: master acked
  logic [3:0]  bit_cnt_reg;
  logic [7:0]  shift_reg;
  logic [7:0]  tx_reg;
  logic [7:0]  hi_reg;
  logic [15:0] ptr_reg;
  logic        sda_oe_reg;
  logic        busy_reg;
  logic        wr_stb_reg;
  logic [15:0] wr_addr_reg;
  logic [7:0]  wr_data_reg;

  logic [7:0]  rx_byte;
  logic        wr_fire;
  logic [7:0]  rd_data_reg;
  logic [7:0]  mem [0:(2**AW)-1];

  assign rx_byte = {shift_reg[6:0], sda_f};
  // scl_rise needs scl_prev low, START/STOP need it high, so they never
  // coincide with a write.
  assign wr_fire = (state_reg == ST_WD) && scl_rise && (bit_cnt_reg == 4'd7);

  // Register file: no reset so it maps onto block RAM. The read port is
  // registered; ptr settles long before the SCL fall that consumes it.
  always_ff @(posedge CLK_50) begin
    if (wr_fire) begin
      mem[ptr_reg[AW-1:0]] <= rx_byte;
    end
    rd_data_reg <= mem[ptr_reg[AW-1:0]];
  end

  always_ff @(posedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg    <= ST_IDLE;
      ack_next_reg <= ST_IDLE;
      phase_reg    <= 1'b0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      tx_reg       <= '0;
      hi_reg       <= '0;
      ptr_reg      <= '0;
      sda_oe_reg   <= 1'b0;
      busy_reg     <= 1'b0;
      wr_stb_reg   <= 1'b0;
      wr_addr_reg  <= '0;
      wr_data_reg  <= '0;
      scl_prev_reg <= 1'b1;
      sda_prev_reg <= 1'b1;
    end else begin
      scl_prev_reg <= scl_f;
      sda_prev_reg <= sda_f;
      wr_stb_reg   <= 1'b0;

      if (stop_det) begin
        state_reg   <= ST_IDLE;
        sda_oe_reg  <= 1'b0;
        busy_reg    <= 1'b0;
        bit_cnt_reg <= '0;
        phase_reg   <= 1'b0;
      end else if (start_det) begin
        // Also covers repeated START and a START that aborts a partial byte.
        state_reg   <= ST_DEV;
        sda_oe_reg  <= 1'b0;
        bit_cnt_reg <= '0;
        phase_reg   <= 1'b0;
      end else begin
        case (state_reg)
          ST_DEV, ST_HI, ST_LO, ST_WD: begin
            if (scl_rise) begin
              shift_reg   <= rx_byte;
              bit_cnt_reg <= bit_cnt_reg + 4'd1;
              if (bit_cnt_reg == 4'd7) begin
                bit_cnt_reg <= '0;
                phase_reg   <= 1'b0;
                state_reg   <= ST_ACK;
                case (state_reg)
                  ST_DEV: begin
                    if (rx_byte[7:1] == DEV_ADDR) begin
                      busy_reg     <= 1'b1;
                      ack_next_reg <= rx_byte[0] ? ST_RD : ST_HI;
                    end else begin
                      state_reg <= ST_IGNORE;
                    end
                  end
                  ST_HI: begin
                    hi_reg       <= rx_byte;
                    ack_next_reg <= ST_LO;
                  end
                  ST_LO: begin
                    ptr_reg      <= {hi_reg, rx_byte};
                    ack_next_reg <= ST_WD;
                  end
                  default: begin
                    wr_stb_reg   <= 1'b1;
                    wr_addr_reg  <= ptr_reg;
                    wr_data_reg  <= rx_byte;
                    ptr_reg      <= ptr_reg + 16'd1;
                    ack_next_reg <= ST_WD;
                  end
                endcase
              end
            end
          end

          ST_ACK: begin
            // First fall opens the ACK slot, second fall closes it.
            if (scl_fall) begin
              if (!phase_reg) begin
                sda_oe_reg <= 1'b1;
                phase_reg  <= 1'b1;
              end else begin
                phase_reg <= 1'b0;
                state_reg <= ack_next_reg;
                if (ack_next_reg == ST_RD) begin
                  tx_reg      <= rd_data_reg;
                  sda_oe_reg  <= ~rd_data_reg[7];
                  bit_cnt_reg <= '0;
                end else begin
                  sda_oe_reg <= 1'b0;
                end
              end
            end
          end

          ST_RD: begin
            if (scl_rise) begin
              bit_cnt_reg <= bit_cnt_reg + 4'd1;
              if (bit_cnt_reg == 4'd7) begin
                ptr_reg <= ptr_reg + 16'd1;
              end
            end else if (scl_fall) begin
              if (bit_cnt_reg == 4'd8) begin
                sda_oe_reg  <= 1'b0;
                state_reg   <= ST_MACK;
                bit_cnt_reg <= '0;
                phase_reg   <= 1'b0;
              end else begin
                // tx_reg[7] is already on the bus; present the next bit.
                sda_oe_reg <= ~tx_reg[6];
                tx_reg     <= {tx_reg[6:0], 1'b0};
              end
            end
          end

          ST_MACK: begin
            if (scl_rise) begin
              if (sda_f) begin
                state_reg <= ST_IGNORE;
              end else begin
                phase_reg <= 1'b1;
              end
            end else if (scl_fall && phase_reg) begin
              phase_reg   <= 1'b0;
              state_reg   <= ST_RD;
              tx_reg      <= rd_data_reg;
              sda_oe_reg  <= ~rd_data_reg[7];
              bit_cnt_reg <= '0;
            end
          end

          ST_IDLE, ST_IGNORE: begin
          end

          default: begin
            state_reg  <= ST_IDLE;
            sda_oe_reg <= 1'b0;
          end
        endcase
      end
    end
  end

  assign I2C_SDA = sda_oe_reg ? 1'b0 : 1'bz;
  assign WR_STB  = wr_stb_reg;
  assign WR_ADDR = wr_addr_reg;
  assign WR_DATA = wr_data_reg;
  assign BUSY    = busy_reg;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// ---------------------------------------------------------------------------
// tb_i2c_target_regfile
//
// Bit-banged I2C master driving i2c_target_regfile. Main traffic comes from a
// table of bus operations with expected ACK, read data, write strobe and BUSY.
// Glitch rejection, mid-byte abort and reset during a read are hand-written
// sequences. Expected writes go into a queue that a WR_STB monitor pops.
// ---------------------------------------------------------------------------
module tb_i2c_target_regfile;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scl_drv = 1'b1;
  logic        sda_low = 1'b0;
  wire         sda_line;
  logic        wr_stb;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy;

  assign sda_line = sda_low ? 1'b0 : 1'bz;
  pullup (sda_line);

  always #10 clk = ~clk;

  i2c_target_regfile dut (
    .CLK_50  (clk),
    .RESET_N (rst_n),
    .I2C_SCL (scl_drv),
    .I2C_SDA (sda_line),
    .WR_STB  (wr_stb),
    .WR_ADDR (wr_addr),
    .WR_DATA (wr_data),
    .BUSY    (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t         wr_q[$];
  logic [7:0]  rd_q[$];
  int          stb_count = 0;
  int          exp_stb_total = 0;
  logic        stb_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // WR_STB monitor: every strobe must match the oldest expected write and
  // last exactly one cycle.
  always @(negedge clk) begin
    if (wr_stb) begin
      stb_count++;
      n_checks++;
      if (wr_q.size() == 0) begin
        n_fail++;
        $display("FAIL wr_stb_unexpected: got addr=%h data=%h, required no strobe",
                 wr_addr, wr_data);
      end else begin
        wr_t e;
        e = wr_q.pop_front();
        if ({wr_addr, wr_data} !== e) begin
          n_fail++;
          $display("FAIL wr_stb_payload: got addr=%h data=%h, required addr=%h data=%h",
                   wr_addr, wr_data, e.addr, e.data);
        end
      end
      n_checks++;
      if (stb_prev) begin
        n_fail++;
        $display("FAIL wr_stb_width: got 2+ cycle pulse, required 1 cycle");
      end
    end
    stb_prev = wr_stb;
  end

  // -------------------------------------------------------------------------
  // Bit-level master
  // -------------------------------------------------------------------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    if (!scl_drv) begin
      cyc(10);
      sda_low = 1'b0;
      cyc(30);
      scl_drv = 1'b1;
      cyc(40);
    end
    sda_low = 1'b1;
    cyc(40);
    scl_drv = 1'b0;
    cyc(10);
  endtask

  task automatic i2c_stop();
    cyc(10);
    sda_low = 1'b1;
    cyc(30);
    scl_drv = 1'b1;
    cyc(40);
    sda_low = 1'b0;
    cyc(40);
  endtask

  // glitch: 2-cycle SCL high pulse in the low phase and 2-cycle SCL low
  // pulse in the high phase; both must be filtered out.
  task automatic send_bit(input logic v, input bit glitch);
    cyc(10);
    sda_low = ~v;
    if (glitch) begin
      cyc(10);
      scl_drv = 1'b1;
      cyc(2);
      scl_drv = 1'b0;
      cyc(18);
    end else begin
      cyc(30);
    end
    scl_drv = 1'b1;
    if (glitch) begin
      cyc(15);
      scl_drv = 1'b0;
      cyc(2);
      scl_drv = 1'b1;
      cyc(23);
    end else begin
      cyc(40);
    end
    scl_drv = 1'b0;
  endtask

  task automatic i2c_write(input logic [7:0] b, input bit glitch, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      send_bit(b[i], glitch);
    end
    cyc(10);
    sda_low = 1'b0;
    cyc(30);
    scl_drv = 1'b1;
    cyc(20);
    ack = sda_line;
    cyc(20);
    scl_drv = 1'b0;
  endtask

  task automatic i2c_read(input logic mack, output logic [7:0] b);
    logic [7:0] r;
    r = '0;
    sda_low = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      cyc(40);
      scl_drv = 1'b1;
      cyc(20);
      r[i] = sda_line;
      cyc(20);
      scl_drv = 1'b0;
    end
    cyc(10);
    sda_low = ~mack;
    cyc(30);
    scl_drv = 1'b1;
    cyc(40);
    scl_drv = 1'b0;
    cyc(10);
    sda_low = 1'b0;
    b = r;
  endtask

  task automatic wr_chk(input string name, input logic [7:0] b, input bit glitch,
                        input logic exp_ack);
    logic a;
    i2c_write(b, glitch, a);
    chk(name, a, exp_ack);
  endtask

  task automatic rd_chk(input string name, input logic mack, input logic [7:0] exp);
    logic [7:0] r;
    rd_q.push_back(exp);
    i2c_read(mack, r);
    chk(name, r, rd_q.pop_front());
  endtask

  task automatic expect_wr(input logic [15:0] a, input logic [7:0] d);
    wr_q.push_back({a, d});
    exp_stb_total++;
  endtask

  // -------------------------------------------------------------------------
  // Operation table
  // -------------------------------------------------------------------------
  typedef enum int {OP_START, OP_STOP, OP_WR, OP_RD} op_e;

  typedef struct {
    op_e         op;
    logic [7:0]  data;   // byte written, or byte expected on a read
    logic        ack;    // WR: expected target ACK; RD: ack sent by master
    logic        stb;    // WR: a register write is expected
    logic [15:0] addr;   // WR: expected WR_ADDR
    logic        busy;   // expected BUSY after the operation
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(op_e op, logic [7:0] d, logic a, logic s,
                              logic [15:0] ad, logic bz);
    vec_t v;
    v.op   = op;
    v.data = d;
    v.ack  = a;
    v.stb  = s;
    v.addr = ad;
    v.busy = bz;
    return v;
  endfunction

  initial begin
    int stb_before;

    // Write 0x12, 0x34 at 0x0004.
    vecs.push_back(mk(OP_START, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0));
    vecs.push_back(mk(OP_WR,    8'h1C, 1'b0, 1'b0, 16'h0000, 1'b1));
    vecs.push_back(mk(OP_WR,    8'h00, 1'b0, 1'b0, 16'h0000, 1'b1));
    vecs.push_back(mk(OP_WR,    8'h04, 1'b0, 1'b0, 16'h0000, 1'b1));
    vecs.push_back(mk(OP_WR,    8'h12, 1'b0, 1'b1, 16'h0004, 1'b1));
    vecs.push_back(mk(OP_WR,    8'h34, 1'b0, 1'b1, 16'h0005, 1'b1));
    vecs.push_back(mk(OP_STOP,  8'h00, 1'b0, 1'b0, 16'h0000, 1'b0));
    // Combined-format read of 2 bytes at 0x0004.
    vecs.push_back(mk(OP_START, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0));
    vecs.push_back(mk(OP_WR,    8'h1C, 1'b0, 1'b0, 16'h0000, 1'b1));
    vecs.push_back(mk(OP_WR,    8'h00, 1'b0, 1'b0, 16'h0000, 1'b1));
    vecs.push_back(mk(OP_WR,    8'h04, 1'b0, 1'b0, 16'h0000, 1'b1));
    vecs.push_back(mk(OP_START, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b1));
    vecs.push_back(mk(OP_WR,    8'h1D, 1'b0, 1'b0, 16'h0000, 1'b1));
    vecs.push_back(mk(OP_RD,    8'h12, 1'b0, 1'b0, 16'h0000, 1'b1));
    vecs.push_back(mk(OP_RD,    8'h34, 1'b1, 1'b0, 16'h0000, 1'b1));
    vecs.push_back(mk(OP_STOP,  8'h00, 1'b0, 1'b0, 16'h0000, 1'b0));
    // Pointer wrap 0xFFFF -> 0x0000.
    vecs.push_back(mk(OP_START, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0));
    vecs.push_back(mk(OP_WR,    8'h1C, 1'b0, 1'b0, 16'h0000, 1'b1));
    vecs.push_back(mk(OP_WR,    8'hFF, 1'b0, 1'b0, 16'h0000, 1'b1));
    vecs.push_back(mk(OP_WR,    8'hFF, 1'b0, 1'b0, 16'h0000, 1'b1));
    vecs.push_back(mk(OP_WR,    8'hAA, 1'b0, 1'b1, 16'hFFFF, 1'b1));
    vecs.push_back(mk(OP_WR,    8'hBB, 1'b0, 1'b1, 16'h0000, 1'b1));
    vecs.push_back(mk(OP_STOP,  8'h00, 1'b0, 1'b0, 16'h0000, 1'b0));
    // Aliasing: 0x01FF maps to entry 0xFF, then 0x0200 to entry 0x00.
    vecs.push_back(mk(OP_START, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0));
    vecs.push_back(mk(OP_WR,    8'h1C, 1'b0, 1'b0, 16'h0000, 1'b1));
    vecs.push_back(mk(OP_WR,    8'h01, 1'b0, 1'b0, 16'h0000, 1'b1));
    vecs.push_back(mk(OP_WR,    8'hFF, 1'b0, 1'b0, 16'h0000, 1'b1));
    vecs.push_back(mk(OP_START, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b1));
    vecs.push_back(mk(OP_WR,    8'h1D, 1'b0, 1'b0, 16'h0000, 1'b1));
    vecs.push_back(mk(OP_RD,    8'hAA, 1'b0, 1'b0, 16'h0000, 1'b1));
    vecs.push_back(mk(OP_RD,    8'hBB, 1'b1, 1'b0, 16'h0000, 1'b1));
    vecs.push_back(mk(OP_STOP,  8'h00, 1'b0, 1'b0, 16'h0000, 1'b0));
    // Wrong device address 0x10: no ACK, no write, BUSY stays low.
    vecs.push_back(mk(OP_START, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0));
    vecs.push_back(mk(OP_WR,    8'h20, 1'b1, 1'b0, 16'h0000, 1'b0));
    vecs.push_back(mk(OP_WR,    8'h55, 1'b1, 1'b0, 16'h0000, 1'b0));
    vecs.push_back(mk(OP_STOP,  8'h00, 1'b0, 1'b0, 16'h0000, 1'b0));

    // Reset state.
    cyc(5);
    chk("rst_wr_stb", wr_stb, 1'b0);
    chk("rst_wr_addr", wr_addr, 16'h0000);
    chk("rst_wr_data", wr_data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_sda", sda_line, 1'b1);
    rst_n = 1'b1;
    cyc(20);

    foreach (vecs[i]) begin
      case (vecs[i].op)
        OP_START: i2c_start();
        OP_STOP:  i2c_stop();
        OP_WR: begin
          if (vecs[i].stb) expect_wr(vecs[i].addr, vecs[i].data);
          wr_chk($sformatf("v%0d_ack", i), vecs[i].data, 1'b0, vecs[i].ack);
        end
        default: begin
          rd_chk($sformatf("v%0d_rd", i), vecs[i].ack, vecs[i].data);
        end
      endcase
      chk($sformatf("v%0d_busy", i), busy, vecs[i].busy);
    end

    // Glitch rejection on a data byte, then read it back.
    i2c_start();
    wr_chk("gl_dev", 8'h1C, 1'b0, 1'b0);
    wr_chk("gl_hi", 8'h00, 1'b0, 1'b0);
    wr_chk("gl_lo", 8'h10, 1'b0, 1'b0);
    expect_wr(16'h0010, 8'h5A);
    wr_chk("gl_data", 8'h5A, 1'b1, 1'b0);
    i2c_stop();
    chk("gl_wr_data", wr_data, 8'h5A);
    i2c_start();
    wr_chk("gl_rdev", 8'h1C, 1'b0, 1'b0);
    wr_chk("gl_rhi", 8'h00, 1'b0, 1'b0);
    wr_chk("gl_rlo", 8'h10, 1'b0, 1'b0);
    i2c_start();
    wr_chk("gl_rdevr", 8'h1D, 1'b0, 1'b0);
    rd_chk("gl_rd", 1'b1, 8'h5A);
    i2c_stop();

    // Repeated START after 4 data bits aborts the byte.
    stb_before = stb_count;
    i2c_start();
    wr_chk("ab_dev", 8'h1C, 1'b0, 1'b0);
    wr_chk("ab_hi", 8'h00, 1'b0, 1'b0);
    wr_chk("ab_lo", 8'h20, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    i2c_start();
    wr_chk("ab_dev2", 8'h1C, 1'b0, 1'b0);
    chk("ab_busy", busy, 1'b1);
    wr_chk("ab_hi2", 8'h00, 1'b0, 1'b0);
    wr_chk("ab_lo2", 8'h04, 1'b0, 1'b0);
    i2c_start();
    wr_chk("ab_devr", 8'h1D, 1'b0, 1'b0);
    rd_chk("ab_rd", 1'b1, 8'h12);
    i2c_stop();
    chk("ab_no_stb", stb_count, stb_before);
    chk("ab_wr_addr", wr_addr, 16'h0010);

    // Reset while the target pulls SDA low (bit 7 of 0x12 is 0).
    i2c_start();
    wr_chk("rs_dev", 8'h1C, 1'b0, 1'b0);
    wr_chk("rs_hi", 8'h00, 1'b0, 1'b0);
    wr_chk("rs_lo", 8'h04, 1'b0, 1'b0);
    i2c_start();
    wr_chk("rs_devr", 8'h1D, 1'b0, 1'b0);
    cyc(15);
    chk("rs_drive_low", sda_line, 1'b0);
    chk("rs_busy_pre", busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rs_sda_released", sda_line, 1'b1);
    chk("rs_busy", busy, 1'b0);
    cyc(3);
    rst_n = 1'b1;
    cyc(10);
    i2c_stop();
    i2c_start();
    wr_chk("rs_dev2", 8'h1C, 1'b0, 1'b0);
    wr_chk("rs_hi2", 8'h00, 1'b0, 1'b0);
    wr_chk("rs_lo2", 8'h04, 1'b0, 1'b0);
    i2c_start();
    wr_chk("rs_devr2", 8'h1D, 1'b0, 1'b0);
    rd_chk("rs_rd", 1'b1, 8'h12);
    i2c_stop();
    chk("rs_busy_end", busy, 1'b0);

    cyc(20);
    chk("wr_q_drained", wr_q.size(), 0);
    chk("stb_total", stb_count, exp_stb_total);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_target_regfile.md
# i2c_target_regfile

I2C target (responder) that answers the write/read transactions issued by the camera and MIPI-bridge I2C configuration masters. It holds a small byte-wide register file addressed by a 16-bit register index, which lets a bench or loopback build check a full configuration sequence without the D8M hardware attached. It runs on the 50 MHz system clock and oversamples SCL/SDA; it never stretches the clock.

## Interface
- DEV_ADDR, 7'h0E, 7-bit target address this block acknowledges
- AW, 8, register-file index width; depth 2**AW bytes, using register address bits [AW-1:0]
- FILT, 3, number of consecutive equal samples required to accept a new SCL/SDA level
- CLK_50  in  1  system clock; all logic on its rising edge
- RESET_N  in  1  asynchronous active-low reset
- I2C_SCL  in  1  bus clock from the master
- I2C_SDA  inout  1  open-drain data; the block only drives 0, otherwise Z
- WR_STB  out  1  one-cycle pulse when a data byte is written into the register file
- WR_ADDR  out  16  register address of the last written byte
- WR_DATA  out  8  value of the last written byte
- BUSY  out  1  high from accepted START (matching address) to STOP

## Operation
- Input path: 2-flop synchronizer on SCL and SDA, then a FILT-sample glitch filter on each. All decoding uses the filtered signals scl_f and sda_f, with edge flags derived from their previous values.
- START (and repeated START): sda_f falls while scl_f is high. Clears the bit counter and enters DEV.
- STOP: sda_f rises while scl_f is high. Returns to IDLE from any state, releases SDA, clears BUSY.
- Data is sampled on the scl_f rising edge, MSB first. SDA is changed only on the cycle after an scl_f falling edge.
- States and transitions:
  - IDLE → DEV on START.
  - DEV: shift in 8 bits.
    - Address matches DEV_ADDR, R/W=0 → ACK_DEV, then HI.
    - Matches, R/W=1 → ACK_DEV, then RD.
    - No match → IGNORE. SDA is never driven; stay in IGNORE until START or STOP.
  - HI: receive the address MSB byte → ACK → LO.
  - LO: receive the address LSB byte → ACK → WD. The register pointer ptr[15:0] is now loaded.
  - WD: receive a byte → ACK.
    - On the 8th rising edge: write mem[ptr[AW-1:0]], pulse WR_STB, update WR_ADDR/WR_DATA, then ptr←ptr+1.
    - Repeat until STOP or repeated START.
  - RD: drive mem[ptr[AW-1:0]] MSB first. Bit 7 is driven after the falling edge that ends the ACK slot; ptr increments after the 8th bit. Then MACK.
  - MACK: sample the master's ack bit.
    - 0 → RD with the next byte.
    - 1 (NACK) → release SDA, go to IGNORE and wait for STOP or START.
- ACK slots: the target drives SDA=0 from the falling edge after bit 8 until the next falling edge.
- ptr wraps 16'hFFFF → 16'h0000. The register file aliases modulo 2**AW.
- ptr persists across transactions, so a write of only HI/LO followed by a repeated-START read reads from that address (combined format).
- A START that arrives mid-byte aborts the byte with no write and re-enters DEV.

## Timing
- Reset values:
  - state=IDLE, SDA released (Z), WR_STB=0, WR_ADDR=0, WR_DATA=0, BUSY=0, ptr=0.
  - Register file contents are undefined.
- Input latency: 2 sync cycles + FILT cycles, i.e. 5 CLK_50 cycles at default.
- SDA drive updates 1 cycle after the internal scl_f fall flag, so at most 6 cycles after the physical SCL fall at default.
- Master requirements: SCL low ≥ 20 CLK_50 cycles and SDA hold after SCL fall ≥ 1 cycle. Both hold at 100/400 kHz.
- WR_STB asserts 1 cycle after the 8th data-bit rising edge is detected and lasts exactly 1 cycle.
- BUSY rises the cycle the ACK_DEV state is entered and falls the cycle STOP is detected.
- An asynchronous RESET_N assertion mid-transfer releases SDA immediately, with no clock required.

## Test plan
- **Write then read back:** write 0x0E, addr 0x0004, data 0x12, 0x34, STOP.
  - WR_STB pulses twice: (0x0004, 0x12) then (0x0005, 0x34).
  - Then repeated-START read 0x0E/R at addr 0x0004 of 2 bytes, NACK on the last → SDA reads 0x12, 0x34.
- **Wrong address:** address byte 0x10/W → SDA stays high in the ACK slot, no WR_STB, BUSY stays 0 through STOP.
- **Wrap:** write addr 0xFFFF with data 0xAA, 0xBB → WR_ADDR reports 0xFFFF, then 0x0000.
- **Glitch rejection:** inject 2-cycle SCL low pulses during a data byte → received byte unchanged and no extra bit shifted.
- **Abort:** repeated START after 4 bits of a data byte → no WR_STB, and the following address byte is decoded correctly.
- **Reset mid-read:** assert RESET_N low while the target drives SDA=0 → SDA is Z in the same cycle, state IDLE, BUSY=0.
